// File: rtl/series_ctrl_pkg.sv
// ============================================================================
// Module   : series_ctrl_pkg
// Brief    : Shared state encoding and widths for the series pipeline sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package series_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int X_W   = 8;
  localparam int N_W   = 3;
  localparam int RES_W = 32;
  localparam int ENT_W = RES_W + 1;

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module   : result_fifo
// Brief    : Synchronous circular FIFO; head entry is read straight from storage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 33,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == C_LAST) ? '0 : p + AW'(1);
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(DEPTH));
  assign count  = r_count;
  assign w_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push = push & (~full | w_pop);
  assign dout   = empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= f_next(r_wr);
      if (w_pop)  r_rd <= f_next(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/series_controller.sv
// ============================================================================
// Module   : series_controller
// Brief    : Job injection, result capture and watchdog for the series pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module series_controller
  import series_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [N_W-1:0]   in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_ov,
  input  logic             flush_req,
  input  logic             drain_req,
  output logic             busy,
  output logic             timeout_err,
  output logic             dp_load,
  output logic             dp_inuse,
  output logic             dp_flush,
  output logic [X_W-1:0]   dp_x,
  output logic [N_W-1:0]   dp_n,
  input  logic             dp_ready,
  input  logic             dp_valid,
  input  logic             dp_ov,
  input  logic [RES_W-1:0] dp_result
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [CW:0]   C_DEPTH   = (CW + 1)'(DEPTH);
  localparam logic [WW-1:0] C_WD_LAST = WW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_fifo_count;
  logic [WW-1:0] r_wd;
  logic [WW-1:0] w_wd_next;
  logic          r_timeout_err;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_issue;
  logic          w_accept;
  logic          w_pop;
  logic          w_wd_run;
  logic          w_expire;
  logic          w_flushing;
  logic          w_space;
  logic [ENT_W-1:0] w_head;

  assign w_flushing = (r_state == FLUSH);
  // Result space is reserved at issue, so completions can never overflow the FIFO.
  assign w_space    = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < C_DEPTH;
  assign w_accept   = dp_valid & (r_outstanding != '0) & ~w_flushing;
  assign w_wd_run   = (r_outstanding != '0) & ~dp_valid;
  assign w_wd_next  = w_wd_run ? r_wd + WW'(1) : '0;
  assign w_expire   = w_wd_run & (w_wd_next == C_WD_LAST)
                    & ((r_state == RUN) | (r_state == DRAIN));

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    w_issue  = 1'b0;
    dp_inuse = 1'b0;
    dp_x     = '0;
    dp_n     = '0;
    dp_flush = w_flushing;
    dp_load  = rst;
    case (r_state)
      IDLE:    w_next = RUN;
      RUN: begin
        in_ready = dp_ready & ~dp_flush & w_space & ~w_fifo_full;
        if (drain_req) w_next = DRAIN;
      end
      DRAIN:   if (r_outstanding == '0) w_next = RUN;
      FLUSH:   w_next = RUN;
      default: w_next = IDLE;
    endcase
    w_issue = in_valid & in_ready;
    if (w_issue) begin
      dp_inuse = 1'b1;
      dp_x     = in_x;
      dp_n     = in_n;
    end
    if (flush_req | w_expire) w_next = FLUSH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_outstanding <= '0;
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_flushing) begin
        r_outstanding <= '0;
        r_wd          <= '0;
      end else begin
        r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_accept);
        r_wd          <= w_wd_next;
      end
      if (w_expire)       r_timeout_err <= 1'b1;
      else if (flush_req) r_timeout_err <= 1'b0;
    end
  end

  assign w_pop = out_valid & out_ready;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (w_flushing),
    .push  (w_accept),
    .pop   (w_pop),
    .din   ({dp_result, dp_ov}),
    .dout  (w_head),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  assign {out_result, out_ov} = w_head;
  assign out_valid   = ~w_fifo_empty;
  assign busy        = (r_outstanding != '0) | out_valid;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_series_controller.sv
// ============================================================================
// Module   : tb_series_controller
// Brief    : Bench with a fixed-latency pipeline stand-in and a scoreboard model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_series_controller;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 4;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_FLUSH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, out_ov;
  logic [7:0]  in_x, dp_x;
  logic [2:0]  in_n, dp_n;
  logic [31:0] out_result, dp_result;
  logic        flush_req, drain_req, busy, timeout_err;
  logic        dp_load, dp_inuse, dp_flush, dp_ready, dp_valid, dp_ov;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  series_controller #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ov(out_ov),
    .flush_req(flush_req), .drain_req(drain_req), .busy(busy), .timeout_err(timeout_err),
    .dp_load(dp_load), .dp_inuse(dp_inuse), .dp_flush(dp_flush), .dp_x(dp_x), .dp_n(dp_n),
    .dp_ready(dp_ready), .dp_valid(dp_valid), .dp_ov(dp_ov), .dp_result(dp_result)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // Stand-in pipeline: fixed latency, value x*(n+1), overflow flag for n==7.
  function automatic logic [31:0] f_res(input logic [7:0] x, input logic [2:0] n);
    int v;
    v = int'($signed(x)) * (int'(n) + 1);
    return 32'(v);
  endfunction

  typedef struct packed { logic v; logic [7:0] x; logic [2:0] n; } stg_t;
  stg_t pipe [LAT];
  int   recirc;
  logic hold_ready, mute, spurious;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      recirc <= 0;
    end else if (dp_flush) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      recirc <= 0;
    end else begin
      pipe[0] <= {dp_load & dp_inuse, dp_x, dp_n};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (dp_load && dp_inuse && dp_n >= 3'd4) recirc <= int'(dp_n) - 3;
      else if (recirc > 0) recirc <= recirc - 1;
    end
  end

  assign dp_ready  = !hold_ready && (recirc == 0);
  assign dp_valid  = (pipe[LAT-1].v && !mute) || spurious;
  assign dp_result = f_res(pipe[LAT-1].x, pipe[LAT-1].n);
  assign dp_ov     = (pipe[LAT-1].n == 3'd7);

  // Scoreboard model: jobs in flight as a queue, results buffered as a queue.
  int          m_state;
  int          m_quiet;
  bit          m_terr;
  logic [32:0] m_iss[$];
  logic [32:0] m_fifo[$];
  logic [32:0] got[$];
  int          n_issued;
  int          n_flush_cyc;

  always @(negedge clk) begin
    bit e_rdy, iss, acc, pop, quiet, expire;
    int ns, qn;
    if (!rst) begin
      m_state = S_IDLE;
      m_quiet = 0;
      m_terr  = 0;
      m_iss.delete();
      m_fifo.delete();
    end else begin
      e_rdy = (m_state == S_RUN) && dp_ready && (m_iss.size() + m_fifo.size() < DEPTH);
      iss   = in_valid && e_rdy;
      chk("in_ready", in_ready, e_rdy);
      chk("dp_inuse", dp_inuse, iss);
      chk("dp_x", dp_x, iss ? in_x : 8'h00);
      chk("dp_n", dp_n, iss ? in_n : 3'd0);
      chk("dp_flush", dp_flush, m_state == S_FLUSH);
      chk("dp_load", dp_load, 1'b1);
      chk("out_valid", out_valid, m_fifo.size() > 0);
      chk("busy", busy, (m_iss.size() > 0) || (m_fifo.size() > 0));
      chk("timeout_err", timeout_err, m_terr);
      if (m_fifo.size() > 0) chk("out_head", {out_result, out_ov}, m_fifo[0]);

      if (out_valid && out_ready) got.push_back({out_result, out_ov});
      if (in_valid && in_ready) n_issued++;
      if (dp_flush) n_flush_cyc++;

      acc    = dp_valid && (m_iss.size() > 0) && (m_state != S_FLUSH);
      pop    = (m_fifo.size() > 0) && out_ready;
      quiet  = (m_iss.size() > 0) && !dp_valid;
      qn     = quiet ? m_quiet + 1 : 0;
      expire = quiet && (qn == TIMEOUT - 1) && (m_state == S_RUN || m_state == S_DRAIN);

      ns = m_state;
      case (m_state)
        S_IDLE:  ns = S_RUN;
        S_RUN:   if (drain_req) ns = S_DRAIN;
        S_DRAIN: if (m_iss.size() == 0) ns = S_RUN;
        default: ns = S_RUN;
      endcase
      if (flush_req || expire) ns = S_FLUSH;
      if (expire) m_terr = 1;
      else if (flush_req) m_terr = 0;

      if (m_state == S_FLUSH) begin
        m_iss.delete();
        m_fifo.delete();
        m_quiet = 0;
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (acc) m_fifo.push_back(m_iss.pop_front());
        if (iss) m_iss.push_back({f_res(in_x, in_n), in_n == 3'd7});
        m_quiet = qn;
      end
      m_state = ns;
    end
  end

  int last_iss;

  task automatic send(input logic [7:0] x, input logic [2:0] n, output int waited);
    bit ok = 0;
    waited   = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_n     = n;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        last_iss = cyc;
        break;
      end
      waited++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) bound_expired("send");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) bound_expired("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int which);
    if (which == 0) flush_req = 1'b1;
    else if (which == 1) drain_req = 1'b1;
    else spurious = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    drain_req = 1'b0;
    spurious  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w, fl;
    in_valid = 1'b1; in_x = 8'h55; in_n = 3'd5;
    out_ready = 1'b0; flush_req = 1'b0; drain_req = 1'b0;
    hold_ready = 1'b0; mute = 1'b0; spurious = 1'b0;
    n_issued = 0; n_flush_cyc = 0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_ov", out_ov, 0);
    chk("rst_dp_load", dp_load, 0);
    chk("rst_dp_inuse", dp_inuse, 0);
    chk("rst_dp_flush", dp_flush, 0);
    chk("rst_dp_x", dp_x, 0);
    chk("rst_dp_n", dp_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single job: 0x40 * 3 = 192.
    out_ready = 1'b1;
    got.delete();
    send(8'h40, 3'd2, w);
    wait_idle();
    chk("t1_count", got.size(), 1);
    if (got.size() > 0) chk("t1_result", got[0], {32'd192, 1'b0});
    chk("t1_busy", busy, 0);

    // Six back-to-back single-cycle offers with the output stalled.
    out_ready = 1'b0;
    got.delete();
    n_issued = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_x = 8'(i + 1); in_n = 3'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t2_issued", n_issued, 4);
    chk("t2_in_ready_full", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();
    chk("t2_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("t2_order", got[i], {32'(i + 1), 1'b0});

    // Recirculating job offered while the slot is busy, then a trailing job.
    got.delete();
    n_issued = 0;
    hold_ready = 1'b1;
    fork
      send(8'h10, 3'd6, w);
      begin
        repeat (5) @(posedge clk);
        #1 hold_ready = 1'b0;
      end
    join
    chk("t3_wait_hold", w, 5);
    send(8'hFE, 3'd7, w);
    chk("t3_wait_recirc", w, 3);
    wait_idle();
    chk("t3_issued", n_issued, 2);
    chk("t3_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t3_res0", got[0], {32'd112, 1'b0});
      chk("t3_res1", got[1], {32'hFFFF_FFF0, 1'b1});
    end

    // Drain with three jobs outstanding: the next job waits until they complete.
    got.delete();
    send(8'd3, 3'd1, w);
    send(8'd5, 3'd1, w);
    send(8'd7, 3'd1, w);
    pulse(1);
    send(8'd9, 3'd0, w);
    chk("t4_drain_wait", w, 4);
    wait_idle();
    chk("t4_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t4_res0", got[0], {32'd6, 1'b0});
      chk("t4_res1", got[1], {32'd10, 1'b0});
      chk("t4_res2", got[2], {32'd14, 1'b0});
      chk("t4_res3", got[3], {32'd9, 1'b0});
    end

    // Flush with two results buffered and two jobs in flight.
    out_ready = 1'b0;
    got.delete();
    send(8'd1, 3'd0, w);
    send(8'd2, 3'd0, w);
    repeat (6) @(posedge clk); #1;
    send(8'd3, 3'd0, w);
    send(8'd4, 3'd0, w);
    n_flush_cyc = 0;
    pulse(0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t5_flush_cycles", n_flush_cyc, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    @(posedge clk); #1;
    pulse(2);
    repeat (3) @(negedge clk);
    chk("t5_late_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t5_delivered", got.size(), 0);

    // Watchdog: the pipeline never reports completion.
    mute = 1'b1;
    send(8'h20, 3'd3, w);
    fl = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dp_flush) begin
        fl = cyc;
        break;
      end
    end
    if (fl < 0) bound_expired("t6_flush_wait");
    else chk("t6_flush_latency", fl - last_iss, TIMEOUT);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", timeout_err, 1);
    chk("t6_busy", busy, 0);
    @(posedge clk); #1;
    mute = 1'b0;
    pulse(0);
    repeat (3) @(negedge clk);
    chk("t6_err_cleared", timeout_err, 0);

    // Job after recovery still completes normally: -128 * 1.
    got.delete();
    @(posedge clk); #1;
    send(8'h80, 3'd0, w);
    wait_idle();
    chk("t7_count", got.size(), 1);
    if (got.size() > 0) chk("t7_result", got[0], {32'hFFFF_FF80, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
